// File: rtl/i2c_temp_poll_sequencer_if.sv
// I2C master transaction port of the temperature poll sequencer.
// master: sequencer side (drives the request); slave: I2C master engine side.
interface i2c_temp_poll_sequencer_if;
  logic       go;
  logic       rw;
  logic [5:0] N_Byte;
  logic [6:0] dev_add;
  logic [7:0] dwr_DataWriteReg;
  logic [7:0] R_Pointer;
  logic       done;
  logic       ready;
  logic [7:0] drd_lcdData;
  logic       ack_e;

  modport master (
    output go, rw, N_Byte, dev_add, dwr_DataWriteReg, R_Pointer,
    input  done, ready, drd_lcdData, ack_e
  );

  modport slave (
    input  go, rw, N_Byte, dev_add, dwr_DataWriteReg, R_Pointer,
    output done, ready, drd_lcdData, ack_e
  );
endinterface

// File: rtl/i2c_temp_poll_sequencer.sv
// Periodic 2-byte sensor read over the I2C master; result shown as 4 hex chars in LCD RAM.
// Optional transaction watchdog: define I2C_POLL_TIMEOUT_EN.
module i2c_temp_poll_sequencer #(
  parameter int unsigned POLL_CYCLES    = 50000000,
  parameter logic [6:0]  SLAVE_ADDR     = 7'h48,
  parameter logic [7:0]  REG_PTR        = 8'h00,
  parameter logic [4:0]  LCD_BASE       = 5'd16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  i2c_temp_poll_sequencer_if.master        bus,
  output logic                             W,
  output logic [4:0]                       WADD,
  output logic [7:0]                       DIN,
  output logic                             busy
);

  localparam int unsigned   TW    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(POLL_CYCLES - 1);

  if (POLL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("POLL_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ISSUE, ST_XFER, ST_WR} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    byte_q, byte_d;
  logic [1:0]    char_q, char_d;
  logic          err_q, err_d;
  logic          go_q, go_d;
  logic          rw_q, rw_d;
  logic [5:0]    nbyte_q, nbyte_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    dwr_q, dwr_d;
  logic [7:0]    rptr_q, rptr_d;
  logic          w_q, w_d;
  logic [4:0]    wadd_q, wadd_d;
  logic [7:0]    din_q, din_d;

`ifdef I2C_POLL_TIMEOUT_EN
  localparam int unsigned   WW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd_q, wd_d;
`endif

  function automatic logic [7:0] lcd_char(input logic [15:0] d, input logic e,
                                          input logic [1:0] k);
    logic [3:0] n;
    n = 4'(d >> (4'd12 - {k, 2'b00}));
    if (e) begin
      case (k)
        2'd0:    lcd_char = 8'h45;
        2'd3:    lcd_char = 8'h20;
        default: lcd_char = 8'h52;
      endcase
    end else if (n < 4'd10) begin
      lcd_char = 8'h30 + {4'h0, n};
    end else begin
      lcd_char = 8'h37 + {4'h0, n};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    data_d  = data_q;
    byte_d  = byte_q;
    char_d  = char_q;
    err_d   = err_q;
    go_d    = 1'b0;
    rw_d    = rw_q;
    nbyte_d = nbyte_q;
    dev_d   = dev_q;
    dwr_d   = dwr_q;
    rptr_d  = rptr_q;
    w_d     = 1'b0;
    wadd_d  = '0;
    din_d   = '0;
`ifdef I2C_POLL_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (timer_q == TLAST) begin
          state_d = ST_ISSUE;
          go_d    = 1'b1;
          rw_d    = 1'b1;
          nbyte_d = 6'd2;
          dev_d   = SLAVE_ADDR;
          rptr_d  = REG_PTR;
          dwr_d   = 8'h00;
          byte_d  = '0;
`ifdef I2C_POLL_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_ISSUE: state_d = ST_XFER;
      ST_XFER: begin
        if (bus.ready) begin
          if (byte_q == 2'd0) data_d[15:8] = bus.drd_lcdData;
          if (byte_q == 2'd1) data_d[7:0]  = bus.drd_lcdData;
          if (byte_q != 2'd2) byte_d = byte_q + 2'd1;
        end
        // byte_d already includes a byte arriving alongside done
        if (bus.done) begin
          err_d   = bus.ack_e | (byte_d != 2'd2);
          state_d = ST_WR;
          char_d  = '0;
          w_d     = 1'b1;
          wadd_d  = LCD_BASE;
          din_d   = lcd_char(data_d, err_d, 2'd0);
        end
`ifdef I2C_POLL_TIMEOUT_EN
        else if (wd_q == WLAST) begin
          err_d   = 1'b1;
          state_d = ST_WR;
          char_d  = '0;
          w_d     = 1'b1;
          wadd_d  = LCD_BASE;
          din_d   = lcd_char(data_d, 1'b1, 2'd0);
        end else begin
          wd_d = wd_q + WW'(1);
        end
`endif
      end
      ST_WR: begin
        if (char_q == 2'd3) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end else begin
          char_d = char_q + 2'd1;
          w_d    = 1'b1;
          wadd_d = LCD_BASE + 5'(char_d);
          din_d  = lcd_char(data_q, err_q, char_d);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      data_q  <= '0;
      byte_q  <= '0;
      char_q  <= '0;
      err_q   <= 1'b0;
      go_q    <= 1'b0;
      rw_q    <= 1'b0;
      nbyte_q <= '0;
      dev_q   <= '0;
      dwr_q   <= '0;
      rptr_q  <= '0;
      w_q     <= 1'b0;
      wadd_q  <= '0;
      din_q   <= '0;
`ifdef I2C_POLL_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      byte_q  <= byte_d;
      char_q  <= char_d;
      err_q   <= err_d;
      go_q    <= go_d;
      rw_q    <= rw_d;
      nbyte_q <= nbyte_d;
      dev_q   <= dev_d;
      dwr_q   <= dwr_d;
      rptr_q  <= rptr_d;
      w_q     <= w_d;
      wadd_q  <= wadd_d;
      din_q   <= din_d;
`ifdef I2C_POLL_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign bus.go               = go_q;
  assign bus.rw               = rw_q;
  assign bus.N_Byte           = nbyte_q;
  assign bus.dev_add          = dev_q;
  assign bus.dwr_DataWriteReg = dwr_q;
  assign bus.R_Pointer        = rptr_q;
  assign W                    = w_q;
  assign WADD                 = wadd_q;
  assign DIN                  = din_q;
  assign busy                 = (state_q != ST_IDLE) && (state_q != ST_WAIT);

endmodule

// File: tb/tb_i2c_temp_poll_sequencer.sv
// Randomized bench for i2c_temp_poll_sequencer: two instances (LCD_BASE 16 and 30) share stimulus.
// Expected LCD text is derived from the polled bytes as a hex string or "ERR ".
module tb_i2c_temp_poll_sequencer;
  localparam int unsigned POLL = 10;
  localparam int unsigned TMO  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       done_r = 1'b0, ready_r = 1'b0, ack_r = 1'b0;
  logic [7:0] data_r = '0;
  logic       w_a, w_b, busy_a, busy_b;
  logic [4:0] wadd_a, wadd_b;
  logic [7:0] din_a, din_b;
  int         errors = 0;
  int         checks = 0;
  string      hexdig = "0123456789ABCDEF";

  i2c_temp_poll_sequencer_if bus_a ();
  i2c_temp_poll_sequencer_if bus_b ();

  assign bus_a.done = done_r;
  assign bus_a.ready = ready_r;
  assign bus_a.drd_lcdData = data_r;
  assign bus_a.ack_e = ack_r;
  assign bus_b.done = done_r;
  assign bus_b.ready = ready_r;
  assign bus_b.drd_lcdData = data_r;
  assign bus_b.ack_e = ack_r;

  i2c_temp_poll_sequencer #(.POLL_CYCLES(POLL), .LCD_BASE(5'd16), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus_a),
    .W(w_a), .WADD(wadd_a), .DIN(din_a), .busy(busy_a));

  i2c_temp_poll_sequencer #(.POLL_CYCLES(POLL), .LCD_BASE(5'd30), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus_b),
    .W(w_b), .WADD(wadd_b), .DIN(din_b), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctrl_a"}, {bus_a.go, bus_a.rw, w_a, busy_a}, 0);
    check({tag, "_bus_a"}, {bus_a.N_Byte, bus_a.dev_add, bus_a.R_Pointer, bus_a.dwr_DataWriteReg}, 0);
    check({tag, "_lcd_a"}, {wadd_a, din_a}, 0);
    check({tag, "_all_b"}, {bus_b.go, bus_b.rw, w_b, busy_b, bus_b.N_Byte, bus_b.dev_add, wadd_b, din_b}, 0);
  endtask

  // Waits for go; a poll must start POLL cycles after entering WAIT with no LCD writes meanwhile.
  task automatic wait_go();
    int n = 0;
    int stray = 0;
    do begin
      step();
      n++;
      done_r = 1'b0;
      ack_r = 1'b0;
      if (w_a || w_b) stray++;
      if (n == 1) check("busy_wait", busy_a, 0);
    end while (!bus_a.go && n < 200);
    check("go_seen", bus_a.go, 1);
    check("go_latency", n, POLL + 1);
    check("go_b", bus_b.go, 1);
    check("stray_W", stray, 0);
    check("rw", bus_a.rw, 1);
    check("nbyte", bus_a.N_Byte, 2);
    check("dev_add", bus_a.dev_add, 7'h48);
    check("rptr", bus_a.R_Pointer, 8'h00);
    check("dwr", bus_a.dwr_DataWriteReg, 8'h00);
    check("busy_issue", busy_a, 1);
  endtask

  task automatic check_writes(input logic err, input logic [15:0] word);
    string errs = "ERR ";
    logic [3:0] nib;
    logic [7:0] ch;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      nib = 4'((word >> (12 - 4 * k)) & 16'hF);
      ch = err ? errs[k] : hexdig[nib];
      check($sformatf("W_a%0d", k), w_a, 1);
      check($sformatf("WADD_a%0d", k), wadd_a, (16 + k) % 32);
      check($sformatf("DIN_a%0d", k), din_a, ch);
      check($sformatf("W_b%0d", k), w_b, 1);
      check($sformatf("WADD_b%0d", k), wadd_b, (30 + k) % 32);
      check($sformatf("DIN_b%0d", k), din_b, ch);
      check($sformatf("busy_wr%0d", k), busy_a, 1);
    end
  endtask

  // Called right after go is seen; plays the I2C master side of one read.
  task automatic xact(input int nready, input logic ack, input logic same,
                      input logic [7:0] b0, input logic [7:0] b1, input logic drop_en);
    logic [7:0] bytes [3];
    int stray = 0;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = 8'($urandom);
    step();
    if (bus_a.go || w_a) stray++;
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < nready; i++) begin
      repeat ($urandom_range(0, 3)) begin
        step();
        if (bus_a.go || w_a) stray++;
      end
      ready_r = 1'b1;
      data_r = bytes[i];
      if (!(same && i == nready - 1)) begin
        step();
        if (bus_a.go || w_a) stray++;
        ready_r = 1'b0;
        data_r = '0;
      end
    end
    if (!(same && nready > 0)) begin
      repeat ($urandom_range(0, 3)) begin
        step();
        if (bus_a.go || w_a) stray++;
      end
    end
    done_r = 1'b1;
    ack_r = ack;
    check("hold_rw", bus_a.rw, 1);
    check("hold_nbyte", bus_a.N_Byte, 2);
    check("hold_dev", bus_a.dev_add, 7'h48);
    check("xfer_stray", stray, 0);
    check("busy_xfer", busy_a, 1);
    step();
    done_r = 1'b0;
    ack_r = 1'b0;
    ready_r = 1'b0;
    data_r = '0;
    check_writes(ack || (nready < 2), {b0, b1});
  endtask

  task automatic idle_after_drop();
    int n = 0;
    repeat (25) begin
      step();
      if (bus_a.go || w_a || busy_a || bus_b.go || w_b) n++;
    end
    check("idle_quiet", n, 0);
    enable = 1'b1;
  endtask

  task automatic reset_mid_xfer();
    wait_go();
    step();
    ready_r = 1'b1;
    data_r = 8'h5A;
    step();
    ready_r = 1'b0;
    data_r = '0;
    #2 reset = 1'b1;
    #1;
    check_zero_outputs("rst_async");
    repeat (2) step();
    check_zero_outputs("rst_hold");
    reset = 1'b0;
  endtask

  task automatic no_done_poll();
    wait_go();
`ifdef I2C_POLL_TIMEOUT_EN
    begin
      int n = 0;
      do begin
        step();
        n++;
      end while (!w_a && n < 100);
      check("timeout_latency", n, TMO + 1);
      check_writes(1'b1, 16'h0000);
      done_r = 1'b1;
    end
`else
    begin
      int w = 0;
      repeat (40) begin
        step();
        if (w_a || w_b) w++;
      end
      check("no_timeout", w, 0);
      check("still_busy", busy_a, 1);
      done_r = 1'b1;
      ack_r = 1'b0;
      step();
      done_r = 1'b0;
      check_writes(1'b1, 16'h0000);
    end
`endif
  endtask

  initial begin
    int r;
    int nr;
    #2 reset = 1'b1;
    step();
    step();
    check_zero_outputs("rst_init");
    reset = 1'b0;
    enable = 1'b1;

    wait_go(); xact(2, 1'b0, 1'b0, 8'h1A, 8'hC3, 1'b0);
    wait_go(); xact(2, 1'b1, 1'b0, 8'h1A, 8'hC3, 1'b0);
    wait_go(); xact(1, 1'b0, 1'b0, 8'h77, 8'h88, 1'b0);
    wait_go(); xact(3, 1'b0, 1'b0, 8'hB4, 8'h2E, 1'b0);
    wait_go(); xact(2, 1'b0, 1'b1, 8'h09, 8'hF0, 1'b0);
    wait_go(); xact(1, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
    wait_go(); xact(0, 1'b0, 1'b0, 8'h56, 8'h78, 1'b0);
    wait_go(); xact(2, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
    idle_after_drop();
    reset_mid_xfer();
    no_done_poll();

    for (int p = 0; p < 12; p++) begin
      r = $urandom_range(0, 9);
      nr = (r < 6) ? 2 : (r == 6) ? 0 : (r == 7) ? 1 : 3;
      wait_go();
      xact(nr, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/i2c_temp_poll_sequencer.md
Name: i2c_temp_poll_sequencer

Overview:
- Upstream sequencer for the I2C master.
- Periodically issues a 2-byte register read to the temperature sensor and collects the returned bytes.
- Converts the 16-bit result to four ASCII hex characters and writes them into the LCD character RAM via the W/WADD/DIN write port.
- Replaces hand-driven transactions when the display runs in sensor-monitor mode.

Parameters:
- POLL_CYCLES, 50000000: clocks from end of one poll cycle to start of next (1 s at 50 MHz).
- SLAVE_ADDR, 7'h48: 7-bit sensor device address driven on dev_add.
- REG_PTR, 8'h00: sensor register pointer driven on R_Pointer.
- LCD_BASE, 5'd16: first LCD RAM address written (line 2, column 0); 4 consecutive addresses are used.
- TIMEOUT_CYCLES, 1000000: transaction watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  polling enabled; level-sensitive
- go  out  1  one-cycle transaction start pulse to master
- rw  out  1  1 = read; constant 1 when go asserts
- N_Byte  out  6  byte count; 6'd2
- dev_add  out  7  slave address; SLAVE_ADDR
- dwr_DataWriteReg  out  8  write data; 8'h00 (unused for reads)
- R_Pointer  out  8  register pointer; REG_PTR
- done  in  1  one-cycle pulse: transaction finished
- ready  in  1  one-cycle pulse: drd_lcdData holds a valid received byte
- drd_lcdData  in  8  received byte
- ack_e  in  1  acknowledge-error flag, valid in the done cycle (1 = NACK)
- W  out  1  LCD RAM write strobe
- WADD  out  5  LCD RAM write address
- DIN  out  8  LCD RAM write data (ASCII)
- busy  out  1  high in any state other than IDLE/WAIT

Behaviour:
- Reset (asynchronous, active-high) values: go=0, rw=0, N_Byte=0, dev_add=0, dwr_DataWriteReg=0, R_Pointer=0, W=0, WADD=0, DIN=0, busy=0, state=IDLE, timer=0, data register=16'h0000, byte index=0.
- Reset asserted mid-transaction aborts immediately; no LCD write is issued.
- States and transitions:
  - IDLE: when enable=1, go to WAIT and clear timer.
  - WAIT: timer increments each cycle. At timer==POLL_CYCLES-1, go to ISSUE. If enable drops, return to IDLE.
  - ISSUE: single cycle. go=1, rw=1, N_Byte=2, dev_add/R_Pointer/dwr_DataWriteReg driven to their fixed values; byte index cleared. Next state XFER.
  - XFER: on each ready pulse:
    - byte index 0: capture drd_lcdData into data[15:8];
    - byte index 1: capture drd_lcdData into data[7:0];
    - ready pulses beyond the second are ignored.
    - On done: err := ack_e OR (fewer than 2 bytes received). Go to WR with char index 0.
    - ready and done in the same cycle: the byte is captured first, and the err evaluation counts that byte.
  - WR: 4 cycles, char index k=0..3. W=1, WADD=LCD_BASE+k (5-bit wrap: 31+1 → 0), DIN = char k.
    - Normal: char k is the ASCII hex of nibble data[15-4k -: 4]. Nibble <10 → 8'h30+n; nibble ≥10 → 8'h37+n (uppercase).
    - err=1: characters are "E","R","R"," " (8'h45, 8'h52, 8'h52, 8'h20).
    - After k=3, go to WAIT with timer cleared.
- enable has no effect inside ISSUE/XFER/WR; the running cycle completes, then WAIT exits to IDLE.
- go is never reasserted before done is received.
- Master-interface outputs hold their values from ISSUE through done.
- W is high exactly 4 cycles per poll.
- Latency from done to first W is 1 cycle.

Optional Feature:
- Macro: I2C_POLL_TIMEOUT_EN.
- Defined: a watchdog counts cycles in XFER. Reaching TIMEOUT_CYCLES forces err=1 and transitions to WR as if done had arrived. A late done arriving afterwards is ignored.
- Undefined: no watchdog; XFER waits indefinitely for done.

Test Plan:
- POLL_CYCLES=10, enable=1, master returns 8'h1A then 8'hC3, done with ack_e=0 → go pulse exactly 10 cycles after entering WAIT. Writes: WADD 16..19 with DIN 8'h31, 8'h41, 8'h43, 8'h33 ("1AC3").
- Same poll, ack_e=1 at done → writes 8'h45, 8'h52, 8'h52, 8'h20 to 16..19.
- Only one ready before done, ack_e=0 → "ERR " written. Extra third ready in a later poll → data remains the first two bytes.
- LCD_BASE=30, data 16'h09F0 → writes to WADD 30, 31, 0, 1 with "09F0".
- reset asserted during XFER → all outputs 0 asynchronously, state IDLE. After release with enable=1, a new full poll cycle starts from WAIT.
- With I2C_POLL_TIMEOUT_EN, TIMEOUT_CYCLES=20, no done → "ERR " written 21 cycles after go. A done issued afterwards produces no extra W.
